pipelined_carry_skip_adder: RTL and testbench

PIPELINED_CARRY_SKIP_ADDER -- requirements
Module: pipelined_carry_skip_adder

---
 rtl/pipelined_carry_skip_adder.sv | 143 ++++++++++++++
 tb/tb_pipelined_carry_skip_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_skip_adder.sv
// ============================================================================
//  Module      : pipelined_carry_skip_adder
//  Description : WIDTH-bit adder split into NBLK = WIDTH/BLOCK carry-skip
//                blocks, one block per pipeline stage, with valid/ready flow
//                control. Optional macro CSA_OVERFLOW_EN adds a registered
//                two's-complement overflow output (ovf).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_carry_skip_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
`ifdef CSA_OVERFLOW_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    // WIDTH must be a whole multiple of BLOCK; one stage per block.
    localparam int NBLK = WIDTH / BLOCK;

    // Whole pipeline moves together whenever the output slot is free or drained.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    generate
        for (genvar i = 0; i < NBLK; i++) begin : g_stage
            // LO   : first bit of this stage's block
            // REM  : operand bits still unconsumed when entering this stage
            // DONE : sum bits known after this stage
            localparam int LO   = i * BLOCK;
            localparam int REM  = WIDTH - LO;
            localparam int DONE = LO + BLOCK;

            logic [REM-1:0]   a_in;
            logic [REM-1:0]   b_in;
            logic             c_in;
            logic             v_in;
            logic [BLOCK-1:0] blk_sum;
            logic [BLOCK:0]   rip;
            logic             blk_p;
            logic             c_d;
            logic [DONE-1:0]  s_d;
            logic [DONE-1:0]  s_q;
            logic             c_q;
            logic             v_q;

            if (i == 0) begin : g_head
                assign a_in = a;
                assign b_in = b;
                assign c_in = cin;
                assign v_in = in_valid;
                assign s_d  = blk_sum;
            end else begin : g_body
                assign a_in = g_stage[i-1].g_ops.a_q;
                assign b_in = g_stage[i-1].g_ops.b_q;
                assign c_in = g_stage[i-1].c_q;
                assign v_in = g_stage[i-1].v_q;
                assign s_d  = {blk_sum, g_stage[i-1].s_q};
            end

            // Ripple-add this block; the skip mux forwards the block carry-in
            // when every bit propagates, bypassing the ripple chain.
            always_comb begin
                rip     = '0;
                blk_sum = '0;
                blk_p   = 1'b1;
                rip[0]  = c_in;
                for (int j = 0; j < BLOCK; j++) begin
                    blk_sum[j] = a_in[j] ^ b_in[j] ^ rip[j];
                    rip[j+1]   = (a_in[j] & b_in[j]) | ((a_in[j] ^ b_in[j]) & rip[j]);
                    blk_p      = blk_p & (a_in[j] ^ b_in[j]);
                end
                c_d = blk_p ? c_in : rip[BLOCK];
            end

            // Stage result, carry and valid; bubbles enter as v_q = 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    s_q <= s_d;
                    c_q <= c_d;
                    v_q <= v_in;
                end
            end

            if (i < NBLK - 1) begin : g_ops
                logic [REM-BLOCK-1:0] a_q;
                logic [REM-BLOCK-1:0] b_q;

                // Carry forward only the operand bits later blocks still need.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (adv) begin
                        a_q <= a_in[REM-1:BLOCK];
                        b_q <= b_in[REM-1:BLOCK];
                    end
                end
            end else begin : g_tail
`ifdef CSA_OVERFLOW_EN
                logic ovf_q;

                // Overflow = carry into the MSB xor carry out of the MSB.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ovf_q <= 1'b0;
                    end else if (adv) begin
                        ovf_q <= rip[BLOCK-1] ^ c_d;
                    end
                end
`endif
            end
        end
    endgenerate

    assign sum       = g_stage[NBLK-1].s_q;
    assign cout      = g_stage[NBLK-1].c_q;
    assign out_valid = g_stage[NBLK-1].v_q;
`ifdef CSA_OVERFLOW_EN
    assign ovf       = g_stage[NBLK-1].g_tail.ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_carry_skip_adder.sv
// ============================================================================
//  Module      : tb_pipelined_carry_skip_adder
//  Description : Directed self-checking bench for pipelined_carry_skip_adder
//                (16/4 main instance, 8/8 single-stage instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_carry_skip_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b, sum;
    logic        cin, in_valid, in_ready, out_valid, out_ready, cout;
    logic [7:0]  a8, b8, sum8;
    logic        cin8, iv8, ir8, ov8, or8, cout8;
`ifdef CSA_OVERFLOW_EN
    logic        ovf, ovf8;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [15:0] vs [6];
    logic        vc [6];
    logic        vco[6];

    always #5 clk = ~clk;

    pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK(4)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .cout(cout), .out_valid(out_valid),
`ifdef CSA_OVERFLOW_EN
        .ovf(ovf),
`endif
        .out_ready(out_ready)
    );

    pipelined_carry_skip_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
        .in_valid(iv8), .in_ready(ir8),
        .sum(sum8), .cout(cout8), .out_valid(ov8),
`ifdef CSA_OVERFLOW_EN
        .ovf(ovf8),
`endif
        .out_ready(or8)
    );

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic c, input logic v);
        a = x; b = y; cin = c; in_valid = v;
    endtask

    task automatic load_table();
        va[0] = 16'h00FF; vb[0] = 16'h0001; vc[0] = 1'b0; vs[0] = 16'h0100; vco[0] = 1'b0;
        va[1] = 16'hF0F0; vb[1] = 16'h0F0F; vc[1] = 1'b1; vs[1] = 16'h0000; vco[1] = 1'b1;
        va[2] = 16'hFFFF; vb[2] = 16'hFFFF; vc[2] = 1'b1; vs[2] = 16'hFFFF; vco[2] = 1'b1;
        va[3] = 16'hABCD; vb[3] = 16'h1111; vc[3] = 1'b0; vs[3] = 16'hBCDE; vco[3] = 1'b0;
        va[4] = 16'h0000; vb[4] = 16'h0000; vc[4] = 1'b1; vs[4] = 16'h0001; vco[4] = 1'b0;
        va[5] = 16'h8001; vb[5] = 16'h7FFF; vc[5] = 1'b0; vs[5] = 16'h0000; vco[5] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; drive(16'h0, 16'h0, 1'b0, 1'b0);
        a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        #2;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (sum !== 16'h0 || cout !== 1'b0) begin bad++; $display("FAIL reset_sum got=%h/%b exp=0000/0", sum, cout); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_skip_chain();
        drive(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL skip_early got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1)
            begin bad++; $display("FAIL skip_chain got v=%b sum=%h c=%b exp v=1 sum=0000 c=1", out_valid, sum, cout); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL skip_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(16'h1234, 16'h4321, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(16'h8000, 16'h8000, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || sum !== 16'h5555 || cout !== 1'b0)
            begin bad++; $display("FAIL b2b_first got v=%b sum=%h c=%b exp v=1 sum=5555 c=0", out_valid, sum, cout); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1)
            begin bad++; $display("FAIL b2b_second got v=%b sum=%h c=%b exp v=1 sum=0000 c=1", out_valid, sum, cout); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_throughput();
        for (int t = 0; t < 10; t++) begin
            if (t < 6) drive(va[t], vb[t], vc[t], 1'b1);
            else       drive(16'h0, 16'h0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (t >= 3 && t < 9) begin
                total++;
                if (out_valid !== 1'b1 || sum !== vs[t-3] || cout !== vco[t-3])
                    begin bad++; $display("FAIL throughput[%0d] got v=%b sum=%h c=%b exp v=1 sum=%h c=%b", t-3, out_valid, sum, cout, vs[t-3], vco[t-3]); end
            end else if (t == 9) begin
                total++;
                if (out_valid !== 1'b0) begin bad++; $display("FAIL throughput_drain got=%b exp=0", out_valid); end
            end
        end
    endtask

    task automatic test_stall();
        for (int t = 0; t < 4; t++) begin
            drive(va[t], vb[t], vc[t], 1'b1);
            @(posedge clk); #1;
        end
        total++;
        if (out_valid !== 1'b1 || sum !== vs[0]) begin bad++; $display("FAIL stall_full got v=%b sum=%h exp v=1 sum=%h", out_valid, sum, vs[0]); end
        drive(va[4], vb[4], vc[4], 1'b1);
        out_ready = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || sum !== vs[0] || cout !== vco[0] || in_ready !== 1'b0)
                begin bad++; $display("FAIL stall_hold[%0d] got v=%b sum=%h c=%b rdy=%b exp v=1 sum=%h c=%b rdy=0", k, out_valid, sum, cout, in_ready, vs[0], vco[0]); end
        end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) drive(16'h0, 16'h0, 1'b0, 1'b0);
            total++;
            if (out_valid !== 1'b1 || sum !== vs[k] || cout !== vco[k])
                begin bad++; $display("FAIL stall_release[%0d] got v=%b sum=%h c=%b exp v=1 sum=%h c=%b", k, out_valid, sum, cout, vs[k], vco[k]); end
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        for (int t = 0; t < 4; t++) begin
            drive(va[t], vb[t], vc[t], 1'b1);
            @(posedge clk); #1;
        end
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || sum !== vs[0]) begin bad++; $display("FAIL midrst_pre got v=%b sum=%h exp v=1 sum=%h", out_valid, sum, vs[0]); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL midrst_clear got v=%b sum=%h c=%b rdy=%b exp v=0 sum=0000 c=0 rdy=1", out_valid, sum, cout, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midrst_discard got=%b exp=0", seen); end
        drive(va[3], vb[3], vc[3], 1'b1);
        @(posedge clk); #1;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || sum !== vs[3] || cout !== vco[3])
            begin bad++; $display("FAIL midrst_resume got v=%b sum=%h c=%b exp v=1 sum=%h c=%b", out_valid, sum, cout, vs[3], vco[3]); end
    endtask

    task automatic test_single_stage();
        a8 = 8'h0F; b8 = 8'hF1; cin8 = 1'b0; iv8 = 1'b1;
        #1;
        total++;
        if (ov8 !== 1'b0) begin bad++; $display("FAIL nblk1_pre got=%b exp=0", ov8); end
        @(posedge clk); #1;
        iv8 = 1'b0;
        total++;
        if (ov8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b1)
            begin bad++; $display("FAIL nblk1_result got v=%b sum=%h c=%b exp v=1 sum=00 c=1", ov8, sum8, cout8); end
        @(posedge clk); #1;
        total++;
        if (ov8 !== 1'b0) begin bad++; $display("FAIL nblk1_drain got=%b exp=0", ov8); end
    endtask

`ifdef CSA_OVERFLOW_EN
    task automatic test_ovf();
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1)
            begin bad++; $display("FAIL ovf_pos got v=%b sum=%h c=%b ovf=%b exp v=1 sum=8000 c=0 ovf=1", out_valid, sum, cout, ovf); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0)
            begin bad++; $display("FAIL ovf_wrap got v=%b sum=%h c=%b ovf=%b exp v=1 sum=0000 c=1 ovf=0", out_valid, sum, cout, ovf); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        load_table();
        test_reset();
        @(posedge clk); #1;
        test_skip_chain();
        test_back_to_back();
        test_throughput();
        test_stall();
        test_reset_midflight();
        @(posedge clk); #1;
        test_single_stage();
`ifdef CSA_OVERFLOW_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
